// File: rtl/io_bridge_if.sv
// rtl/io_bridge_if.sv - CPU request/ack and external stream signals of io_bridge
interface io_bridge_if #(
  parameter int W  = 16,
  parameter int CW = 3
);
  logic          inp_req;
  logic          inp_ack;
  logic [W-1:0]  inp_data;
  logic          out_req;
  logic [W-1:0]  out_data;
  logic          out_ack;
  logic          ext_in_valid;
  logic [W-1:0]  ext_in_data;
  logic          ext_in_ready;
  logic          ext_out_valid;
  logic [W-1:0]  ext_out_data;
  logic          ext_out_ready;
  logic [CW-1:0] in_count;
  logic [CW-1:0] out_count;

  modport slave (
    input  inp_req, out_req, out_data, ext_in_valid, ext_in_data, ext_out_ready,
    output inp_ack, inp_data, out_ack, ext_in_ready, ext_out_valid, ext_out_data,
    output in_count, out_count
  );

  modport master (
    output inp_req, out_req, out_data, ext_in_valid, ext_in_data, ext_out_ready,
    input  inp_ack, inp_data, out_ack, ext_in_ready, ext_out_valid, ext_out_data,
    input  in_count, out_count
  );
endinterface

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - CPU req/ack channels bridged to external streams through two FIFOs
module io_bridge #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  io_bridge_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_DROP} chan_state_t;

  logic [W-1:0]  in_mem  [DEPTH];
  logic [W-1:0]  out_mem [DEPTH];
  logic [AW-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
  logic [CW-1:0] in_cnt, out_cnt;
  chan_state_t   in_state, out_state;
  logic          inp_ack_q, out_ack_q;
  logic [W-1:0]  inp_data_q;
  logic          in_full, in_empty, out_full, out_empty;
  logic          in_push, in_pop, out_push, out_pop;

  assign in_full   = (in_cnt == FULL_CNT);
  assign in_empty  = (in_cnt == '0);
  assign out_full  = (out_cnt == FULL_CNT);
  assign out_empty = (out_cnt == '0);

  // Ready depends on full alone, so a full FIFO never accepts even when popping.
  assign in_push  = bus.ext_in_valid && !in_full;
  assign in_pop   = (in_state == IDLE) && bus.inp_req && !in_empty;
  assign out_push = (out_state == IDLE) && bus.out_req && !out_full;
  assign out_pop  = !out_empty && bus.ext_out_ready;

  assign bus.ext_in_ready  = !in_full;
  assign bus.ext_out_valid = !out_empty;
  assign bus.ext_out_data  = out_mem[out_rd_ptr];
  assign bus.in_count      = in_cnt;
  assign bus.out_count     = out_cnt;
  assign bus.inp_ack       = inp_ack_q;
  assign bus.inp_data      = inp_data_q;
  assign bus.out_ack       = out_ack_q;

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr] <= bus.ext_in_data;
    if (out_push) out_mem[out_wr_ptr] <= bus.out_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      in_cnt     <= '0;
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_cnt    <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop) in_rd_ptr <= in_rd_ptr + 1'b1;
      if (in_push && !in_pop) in_cnt <= in_cnt + 1'b1;
      else if (!in_push && in_pop) in_cnt <= in_cnt - 1'b1;

      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop) out_rd_ptr <= out_rd_ptr + 1'b1;
      if (out_push && !out_pop) out_cnt <= out_cnt + 1'b1;
      else if (!out_push && out_pop) out_cnt <= out_cnt - 1'b1;
    end
  end

  // WAIT_DROP insists on a low request so one held request yields one word.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      in_state   <= IDLE;
      inp_ack_q  <= 1'b0;
      inp_data_q <= '0;
    end else begin
      case (in_state)
        IDLE: begin
          if (in_pop) begin
            inp_data_q <= in_mem[in_rd_ptr];
            inp_ack_q  <= 1'b1;
            in_state   <= ACK;
          end
        end
        ACK: begin
          inp_ack_q <= 1'b0;
          in_state  <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!bus.inp_req) in_state <= IDLE;
        end
        default: begin
          inp_ack_q <= 1'b0;
          in_state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_state <= IDLE;
      out_ack_q <= 1'b0;
    end else begin
      case (out_state)
        IDLE: begin
          if (out_push) begin
            out_ack_q <= 1'b1;
            out_state <= ACK;
          end
        end
        ACK: begin
          out_ack_q <= 1'b0;
          out_state <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!bus.out_req) out_state <= IDLE;
        end
        default: begin
          out_ack_q <= 1'b0;
          out_state <= IDLE;
        end
      endcase
    end
  end
endmodule
